shift_right_seq: RTL and testbench

Multi-pass sequencer around the existing 10-lane × 5-bit `shift_right` lane shifter. One `shift_right` pass moves data right by at most 4 lanes. This block accepts a request for any lane shift from 0 to 10. It runs the word through one shared `shift_right` instance once per cycle, in steps of up to 4 lanes, and returns the result on a valid/ready output. It sits between the request producer and any consumer that needs shifts wider than a single pass can do.

---
 rtl/shift_right_seq.sv | 179 +++++++++++++++++
 tb/tb_shift_right_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_right_seq.sv
// Multi-pass lane shifter: runs a 10-lane x 5-bit word through one shift_right
// instance, up to 4 lanes per cycle, to reach any shift from 0 to 10 lanes.

module shift_right #(
    parameter int LANES    = 10,
    parameter int LANE_W   = 5,
    parameter int MAX_STEP = 4
) (
    input  logic [LANES*LANE_W-1:0] in,
    input  logic [LANE_W-1:0]       fill,
    input  logic [2:0]              shift,
    output logic [LANES*LANE_W-1:0] out,
    output logic                    out_valid
);

    assign out_valid = (shift <= 3'(MAX_STEP));

    genvar gi, gj;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [LANE_W-1:0] cand [MAX_STEP+1];
            logic [LANE_W-1:0] lane_res;

            // cand[s] is what this lane becomes for a shift of s lanes
            for (gj = 0; gj <= MAX_STEP; gj++) begin : g_cand
                if (gi + gj < LANES) begin : g_src
                    assign cand[gj] = in[(gi+gj)*LANE_W +: LANE_W];
                end else begin : g_fill
                    assign cand[gj] = fill;
                end
            end

            always_comb begin
                lane_res = fill;
                if (shift <= 3'(MAX_STEP)) begin
                    lane_res = cand[shift];
                end
            end

            assign out[gi*LANE_W +: LANE_W] = lane_res;
        end
    endgenerate

endmodule

module shift_right_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [49:0] in_data,
    input  logic [3:0]  in_amount,
    input  logic [4:0]  in_fill,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [49:0] out_data,
    output logic        out_sat,
    output logic [2:0]  out_passes,
    output logic        busy
);

    localparam int LANES    = 10;
    localparam int LANE_W   = 5;
    localparam int MAX_STEP = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [LANES*LANE_W-1:0]   data_q, data_d;
    logic [LANE_W-1:0]         fill_q, fill_d;
    logic [3:0]                rem_q, rem_d;
    logic [2:0]                passes_q, passes_d;
    logic                      sat_q, sat_d;

    logic [3:0]                amt_clip;
    logic                      amt_over;
    logic [2:0]                step;
    logic [3:0]                rem_after;
    logic [LANES*LANE_W-1:0]   sh_out;
    logic                      sh_valid;
    logic                      load;

    assign amt_over  = (in_amount > 4'(LANES));
    assign amt_clip  = amt_over ? 4'(LANES) : in_amount;
    assign step      = (rem_q > 4'(MAX_STEP)) ? 3'(MAX_STEP) : rem_q[2:0];
    assign rem_after = rem_q - {1'b0, step};

    shift_right #(
        .LANES    (LANES),
        .LANE_W   (LANE_W),
        .MAX_STEP (MAX_STEP)
    ) u_shift (
        .in        (data_q),
        .fill      (fill_q),
        .shift     (step),
        .out       (sh_out),
        .out_valid (sh_valid)
    );

    // DONE hands off to the next request in the same cycle as the result handshake
    assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q == SHIFT);
    assign out_data   = data_q;
    assign out_sat    = sat_q;
    assign out_passes = passes_q;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        fill_d   = fill_q;
        rem_d    = rem_q;
        passes_d = passes_q;
        sat_d    = sat_q;
        load     = 1'b0;

        case (state_q)
            IDLE: begin
                load = in_valid;
            end
            SHIFT: begin
                data_d   = sh_out;
                rem_d    = rem_after;
                passes_d = passes_q + 3'd1;
                if (rem_after == 4'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            data_d   = in_data;
            fill_d   = in_fill;
            rem_d    = amt_clip;
            sat_d    = amt_over;
            passes_d = 3'd0;
            state_d  = (amt_clip == 4'd0) ? DONE : SHIFT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            data_q   <= '0;
            fill_q   <= '0;
            rem_q    <= '0;
            passes_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            fill_q   <= fill_d;
            rem_q    <= rem_d;
            passes_q <= passes_d;
            sat_q    <= sat_d;
        end
    end

    // Each pass must stay within the shifter's legal range
    a_pass_legal: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == SHIFT) |-> sh_valid);

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed bench for shift_right_seq: scoreboard of expected results checked
// on each output handshake, plus latency, backpressure and reset checks.

module tb_shift_right_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [49:0] in_data;
    logic [3:0]  in_amount;
    logic [4:0]  in_fill;
    logic        out_valid;
    logic        out_ready;
    logic [49:0] out_data;
    logic        out_sat;
    logic [2:0]  out_passes;
    logic        busy;

    shift_right_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amount  (in_amount),
        .in_fill    (in_fill),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .out_passes (out_passes),
        .busy       (busy)
    );

    typedef struct {
        logic [49:0] data;
        logic        sat;
        logic [2:0]  passes;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [49:0] model(input logic [49:0] d, input int amt, input logic [4:0] f);
        logic [49:0] r;
        for (int i = 0; i < 10; i++) begin
            if (i + amt < 10) r[5*i +: 5] = d[5*(i+amt) +: 5];
            else              r[5*i +: 5] = f;
        end
        return r;
    endfunction

    function automatic logic [49:0] lanes_ramp();
        logic [49:0] r;
        for (int i = 0; i < 10; i++) r[5*i +: 5] = 5'(i);
        return r;
    endfunction

    // Drives a request (called just after a falling edge) and records its expected result
    task automatic send(input logic [49:0] d, input logic [3:0] a, input logic [4:0] f, output int acc);
        exp_t e;
        int   n;
        int   amt;
        in_data   = d;
        in_amount = a;
        in_fill   = f;
        in_valid  = 1'b1;
        n = 0;
        #1;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept", in_ready, 1'b1);
        amt      = (a > 10) ? 10 : int'(a);
        acc      = cyc;
        e.data   = model(d, amt, f);
        e.sat    = (a > 10);
        e.passes = 3'((amt + 3) / 4);
        e.acc    = acc;
        q.push_back(e);
        $display("send amount=%0d fill=%02h accepted_cycle=%0d", a, f, acc);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", out_valid, 1'b0);
            end else begin
                if (!seen) begin
                    chk("latency", cyc, q[0].acc + 1 + int'(q[0].passes));
                    seen = 1'b1;
                end
                if (out_ready) begin
                    chk("out_data", out_data, q[0].data);
                    chk("out_sat", out_sat, q[0].sat);
                    chk("out_passes", out_passes, q[0].passes);
                    $display("result data=%013h sat=%0d passes=%0d cycle=%0d", out_data, out_sat, out_passes, cyc);
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        int          acc1, acc2, acc;
        logic [49:0] ramp;
        logic [49:0] rnd;
        logic [3:0]  amts [6];

        ramp      = lanes_ramp();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amount = '0;
        in_fill   = '0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_data", out_data, 50'd0);
        chk("rst_out_sat", out_sat, 1'b0);
        chk("rst_out_passes", out_passes, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Pass-through, two-pass and saturating requests
        send(ramp, 4'd0, 5'h1F, acc);
        drain();
        send(ramp, 4'd6, 5'h1F, acc);
        chk("busy_in_shift", busy, 1'b1);
        #1;
        chk("in_ready_in_shift", in_ready, 1'b0);
        drain();
        send(ramp, 4'd13, 5'h0A, acc);
        drain();

        // Backpressure: result must hold for 5 stalled cycles
        out_ready = 1'b0;
        send(ramp, 4'd3, 5'h1F, acc);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_data", out_data, model(ramp, 3, 5'h1F));
            chk("bp_sat", out_sat, 1'b0);
            chk("bp_passes", out_passes, 3'd1);
            chk("bp_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Back-to-back: second request accepted in the first result's DONE cycle
        send(ramp, 4'd4, 5'h11, acc1);
        send(~ramp, 4'd9, 5'h03, acc2);
        chk("b2b_accept", acc2, acc1 + 2);
        drain();

        // Reset during the second SHIFT cycle of a 10-lane request
        send(ramp, 4'd10, 5'h15, acc);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_out_data", out_data, 50'd0);
        q.delete();
        seen = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            chk("post_rst_valid", out_valid, 1'b0);
        end
        @(negedge clk);

        // Mixed amounts with random data
        amts[0] = 4'd1; amts[1] = 4'd5; amts[2] = 4'd8;
        amts[3] = 4'd11; amts[4] = 4'd15; amts[5] = 4'd2;
        for (int k = 0; k < 6; k++) begin
            rnd = {$urandom, $urandom};
            send(rnd, amts[k], 5'($urandom), acc);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
